ps2_rx_deserializer: RTL

Bit-level PS/2 device-to-host receiver. It synchronises and deglitches the raw PS/2 clock and data lines, then deserialises 11-bit frames (start, 8 data bits LSB-first, odd parity, stop). Each validated byte is presented as received_data with a one-cycle received_data_en strobe. It sits directly upstream of the scancode decoder (break/extended prefix handling), which consumes exactly this byte/strobe pair. It is receive-only: no host-inhibit or host-to-device transmit.

---
 rtl/ps2_rx_deserializer_if.sv | 22 ++
 rtl/ps2_rx_deserializer.sv | 136 +++++++++++++
 2 files changed

// File: rtl/ps2_rx_deserializer_if.sv
// Byte/strobe bus between the PS/2 receiver and its downstream scancode decoder.
// The receiver drives the bus (master); the decoder consumes it (slave).
interface ps2_rx_deserializer_if;
  logic [7:0] received_data;
  logic       received_data_en;
  logic       parity_error;
  logic       frame_error;

  modport master (
    output received_data,
    output received_data_en,
    output parity_error,
    output frame_error
  );

  modport slave (
    input received_data,
    input received_data_en,
    input parity_error,
    input frame_error
  );
endinterface

// File: rtl/ps2_rx_deserializer.sv
// PS/2 device-to-host receiver: synchronises and deglitches the raw lines, then
// deserialises 11-bit frames into a byte with a one-cycle valid or error strobe.
module ps2_rx_deserializer #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ps2_clk,
  input  logic                  ps2_data,
  ps2_rx_deserializer_if.master rx
);

  localparam int FCNT_W = $clog2(FILTER_LEN) + 1;
  localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FILTER_LEN - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_s;
  logic                   data_s;
  logic [FCNT_W-1:0]      filter_cnt;
  logic                   filtered_clk;
  logic                   filtered_clk_d;
  logic                   fall;

  state_t                 state;
  logic [2:0]             bit_cnt;
  logic [7:0]             shift_reg;
  logic                   parity_bit;
  logic [TMO_W-1:0]       tmo_cnt;

  // Lines idle high, so the chains reset to 1 to avoid a false edge on release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync  <= '1;
      data_sync <= '1;
    end else begin
      // NOTE: non-blocking assignments keep every stage one cycle apart; blocking
      // ones would collapse the chain into a single flop.
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
    end
  end

  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filter_cnt     <= '0;
      filtered_clk   <= 1'b1;
      filtered_clk_d <= 1'b1;
    end else begin
      filtered_clk_d <= filtered_clk;
      if (clk_s == filtered_clk) begin
        filter_cnt <= '0;
      end else if (filter_cnt == FCNT_LAST) begin
        filtered_clk <= clk_s;
        filter_cnt   <= '0;
      end else begin
        filter_cnt <= filter_cnt + 1'b1;
      end
    end
  end

  assign fall = filtered_clk_d & ~filtered_clk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= IDLE;
      bit_cnt             <= '0;
      shift_reg           <= '0;
      parity_bit          <= 1'b0;
      tmo_cnt             <= '0;
      rx.received_data    <= '0;
      rx.received_data_en <= 1'b0;
      rx.parity_error     <= 1'b0;
      rx.frame_error      <= 1'b0;
    end else begin
      // NOTE: strobes default low each cycle so any set below lasts exactly one cycle.
      rx.received_data_en <= 1'b0;
      rx.parity_error     <= 1'b0;
      rx.frame_error      <= 1'b0;
      unique case (state)
        IDLE: begin
          tmo_cnt <= '0;
          if (fall && !data_s) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
        end
        default: begin
          if (fall) begin
            tmo_cnt <= '0;
            unique case (state)
              DATA: begin
                shift_reg <= {data_s, shift_reg[7:1]};
                bit_cnt   <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) state <= PARITY;
              end
              PARITY: begin
                parity_bit <= data_s;
                state      <= STOP;
              end
              default: begin
                state <= IDLE;
                // Bad stop bit outranks the parity check; odd parity means the
                // XOR over data and parity bit must be 1.
                if (!data_s) begin
                  rx.frame_error <= 1'b1;
                end else if (!(^{shift_reg, parity_bit})) begin
                  rx.parity_error <= 1'b1;
                end else begin
                  rx.received_data    <= shift_reg;
                  rx.received_data_en <= 1'b1;
                end
              end
            endcase
          end else if (tmo_cnt == TMO_LAST) begin
            state          <= IDLE;
            tmo_cnt        <= '0;
            rx.frame_error <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule
